id: RTL and testbench

ID -- requirements
Module: id

---
 rtl/id.sv | 339 +++++++++++++++++++++++++++++++++
 tb/tb_id.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/id.sv
// id: RV32I instruction decoder with one-cycle latency; every output is registered.
// Optional feature macro CSR_EN adds SYSTEM CSRRW/CSRRS/CSRRC(I) decoding.
module id (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic [31:0] inst_addr,
  output logic [4:0]  rs1_raddr_o,
  output logic [4:0]  rs2_raddr_o,
  output logic [11:0] csr_raddr_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic [4:0]  rd_waddr_o,
  output logic [11:0] csr_waddr_o,
  output logic [31:0] imm_o,
  output logic [1:0]  op1_sel_o,
  output logic [1:0]  op2_sel_o,
  output logic [3:0]  alu_sel_o,
  output logic [2:0]  br_sel_o,
  output logic [2:0]  wb_sel_o,
  output logic [1:0]  mem_rw_o,
  output logic [3:0]  byte_sel_o,
  output logic        un_sign_o
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [1:0] OP1_ZERO = 2'd0;
  localparam logic [1:0] OP1_RS1  = 2'd1;
  localparam logic [1:0] OP1_IMM  = 2'd2;

  localparam logic [1:0] OP2_ZERO = 2'd0;
  localparam logic [1:0] OP2_RS2  = 2'd1;
  localparam logic [1:0] OP2_PC   = 2'd2;
  localparam logic [1:0] OP2_IMM  = 2'd3;

  localparam logic [3:0] ALU_NONE = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_SLL  = 4'd3;
  localparam logic [3:0] ALU_SLT  = 4'd4;
  localparam logic [3:0] ALU_SLTU = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8;
  localparam logic [3:0] ALU_OR   = 4'd9;
  localparam logic [3:0] ALU_AND  = 4'd10;

  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_JUMP = 3'd1;
  localparam logic [2:0] BR_EQ   = 3'd2;
  localparam logic [2:0] BR_NE   = 3'd3;
  localparam logic [2:0] BR_LT   = 3'd4;
  localparam logic [2:0] BR_GE   = 3'd5;
  localparam logic [2:0] BR_LTU  = 3'd6;
  localparam logic [2:0] BR_GEU  = 3'd7;

  localparam logic [2:0] WB_NONE  = 3'd0;
  localparam logic [2:0] WB_ALU   = 3'd1;
  localparam logic [2:0] WB_PC4   = 3'd2;
  localparam logic [2:0] WB_MEM   = 3'd3;
  localparam logic [2:0] WB_STORE = 3'd4;

  localparam logic [1:0] MEM_NONE  = 2'd0;
  localparam logic [1:0] MEM_READ  = 2'd1;
  localparam logic [1:0] MEM_WRITE = 2'd2;

  localparam logic [3:0] BYTE_NONE = 4'b0000;
  localparam logic [3:0] BYTE_B    = 4'b0001;
  localparam logic [3:0] BYTE_H    = 4'b0011;
  localparam logic [3:0] BYTE_W    = 4'b1111;

`ifdef CSR_EN
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [1:0] OP1_CSR    = 2'd3;
  localparam logic [3:0] ALU_PASS2  = 4'd11;
  localparam logic [3:0] ALU_ANDN   = 4'd12;
  localparam logic [2:0] WB_CSR     = 3'd5;
`endif

  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_of = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_of = ALU_SLL;
      3'b010:  alu_of = ALU_SLT;
      3'b011:  alu_of = ALU_SLTU;
      3'b100:  alu_of = ALU_XOR;
      3'b101:  alu_of = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_of = ALU_OR;
      3'b111:  alu_of = ALU_AND;
      default: alu_of = ALU_NONE;
    endcase
  endfunction

  function automatic logic [2:0] br_of(input logic [2:0] f3);
    case (f3)
      3'b000:  br_of = BR_EQ;
      3'b001:  br_of = BR_NE;
      3'b100:  br_of = BR_LT;
      3'b101:  br_of = BR_GE;
      3'b110:  br_of = BR_LTU;
      3'b111:  br_of = BR_GEU;
      default: br_of = BR_NONE;
    endcase
  endfunction

  function automatic logic [3:0] byte_of(input logic [1:0] sz);
    case (sz)
      2'b00:   byte_of = BYTE_B;
      2'b01:   byte_of = BYTE_H;
      2'b10:   byte_of = BYTE_W;
      default: byte_of = BYTE_NONE;
    endcase
  endfunction

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {inst[31:12], 12'b0};
  assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  logic [4:0]  rs1_d, rs2_d, rd_d;
  logic [11:0] csr_raddr_d, csr_waddr_d;
  logic [31:0] imm_d;
  logic [1:0]  op1_d, op2_d, mem_d;
  logic [3:0]  alu_d, byte_d;
  logic [2:0]  br_d, wb_d;
  logic        un_sign_d;

  always_comb begin
    rs1_d       = inst[19:15];
    rs2_d       = inst[24:20];
`ifdef CSR_EN
    csr_raddr_d = inst[31:20];
`else
    csr_raddr_d = '0;
`endif
    rd_d        = '0;
    csr_waddr_d = '0;
    imm_d       = '0;
    op1_d       = OP1_ZERO;
    op2_d       = OP2_ZERO;
    alu_d       = ALU_NONE;
    br_d        = BR_NONE;
    wb_d        = WB_NONE;
    mem_d       = MEM_NONE;
    byte_d      = BYTE_NONE;
    un_sign_d   = 1'b1;
    case (opcode)
      OPC_OP: begin
        rd_d      = inst[11:7];
        op1_d     = OP1_RS1;
        op2_d     = OP2_RS2;
        alu_d     = alu_of(funct3, inst[30]);
        wb_d      = WB_ALU;
        un_sign_d = (funct3 != 3'b011);
      end
      OPC_OP_IMM: begin
        // inst[30] is immediate data except for the srli/srai distinction
        rd_d      = inst[11:7];
        imm_d     = imm_i;
        op1_d     = OP1_RS1;
        op2_d     = OP2_IMM;
        alu_d     = alu_of(funct3, inst[30] & (funct3 == 3'b101));
        wb_d      = WB_ALU;
        un_sign_d = (funct3 != 3'b011);
      end
      OPC_LOAD: begin
        if (funct3[1:0] != 2'b11 && funct3[2:1] != 2'b11) begin
          rd_d      = inst[11:7];
          imm_d     = imm_i;
          op1_d     = OP1_RS1;
          op2_d     = OP2_IMM;
          alu_d     = ALU_ADD;
          wb_d      = WB_MEM;
          mem_d     = MEM_READ;
          byte_d    = byte_of(funct3[1:0]);
          un_sign_d = ~funct3[2];
        end
      end
      OPC_STORE: begin
        if (funct3[2] == 1'b0 && funct3[1:0] != 2'b11) begin
          imm_d  = imm_s;
          op1_d  = OP1_RS1;
          op2_d  = OP2_IMM;
          alu_d  = ALU_ADD;
          wb_d   = WB_STORE;
          mem_d  = MEM_WRITE;
          byte_d = byte_of(funct3[1:0]);
        end
      end
      OPC_BRANCH: begin
        if (funct3[2:1] != 2'b01) begin
          imm_d     = imm_b;
          op1_d     = OP1_RS1;
          op2_d     = OP2_RS2;
          alu_d     = ALU_SUB;
          br_d      = br_of(funct3);
          un_sign_d = ~(funct3[2] & funct3[1]);
        end
      end
      OPC_LUI: begin
        rd_d  = inst[11:7];
        imm_d = imm_u;
        op1_d = OP1_IMM;
        alu_d = ALU_ADD;
        wb_d  = WB_ALU;
      end
      OPC_AUIPC: begin
        rd_d  = inst[11:7];
        imm_d = imm_u;
        op1_d = OP1_IMM;
        op2_d = OP2_PC;
        alu_d = ALU_ADD;
        wb_d  = WB_ALU;
      end
      OPC_JAL: begin
        rd_d  = inst[11:7];
        imm_d = imm_j;
        op1_d = OP1_IMM;
        op2_d = OP2_PC;
        alu_d = ALU_ADD;
        br_d  = BR_JUMP;
        wb_d  = WB_PC4;
      end
      OPC_JALR: begin
        // funct3 is not qualified here: any JALR encoding is taken as a jump
        rd_d  = inst[11:7];
        imm_d = imm_i;
        op1_d = OP1_RS1;
        op2_d = OP2_PC;
        alu_d = ALU_ADD;
        br_d  = BR_JUMP;
        wb_d  = WB_PC4;
      end
`ifdef CSR_EN
      OPC_SYSTEM: begin
        if (funct3[1:0] != 2'b00) begin
          rd_d        = inst[11:7];
          csr_waddr_d = inst[31:20];
          op1_d       = OP1_CSR;
          wb_d        = WB_CSR;
          case (funct3[1:0])
            2'b01:   alu_d = ALU_PASS2;
            2'b10:   alu_d = ALU_OR;
            default: alu_d = ALU_ANDN;
          endcase
          if (funct3[2]) begin
            imm_d = {27'b0, inst[19:15]};
            op2_d = OP2_IMM;
          end else begin
            rs2_d = inst[19:15];
            op2_d = OP2_RS2;
          end
        end
      end
`endif
      default: ;
    endcase
  end

  logic [4:0]  rs1_q, rs2_q, rd_q;
  logic [11:0] csr_raddr_q, csr_waddr_q;
  logic [31:0] inst_q, inst_addr_q, imm_q;
  logic [1:0]  op1_q, op2_q, mem_q;
  logic [3:0]  alu_q, byte_q;
  logic [2:0]  br_q, wb_q;
  logic        un_sign_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs1_q       <= '0;
      rs2_q       <= '0;
      csr_raddr_q <= '0;
      inst_q      <= '0;
      inst_addr_q <= '0;
      rd_q        <= '0;
      csr_waddr_q <= '0;
      imm_q       <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      alu_q       <= '0;
      br_q        <= '0;
      wb_q        <= '0;
      mem_q       <= '0;
      byte_q      <= '0;
      un_sign_q   <= 1'b0;
    end else begin
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      csr_raddr_q <= csr_raddr_d;
      inst_q      <= inst;
      inst_addr_q <= inst_addr;
      rd_q        <= rd_d;
      csr_waddr_q <= csr_waddr_d;
      imm_q       <= imm_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      alu_q       <= alu_d;
      br_q        <= br_d;
      wb_q        <= wb_d;
      mem_q       <= mem_d;
      byte_q      <= byte_d;
      un_sign_q   <= un_sign_d;
    end
  end

  assign rs1_raddr_o = rs1_q;
  assign rs2_raddr_o = rs2_q;
  assign csr_raddr_o = csr_raddr_q;
  assign inst_o      = inst_q;
  assign inst_addr_o = inst_addr_q;
  assign rd_waddr_o  = rd_q;
  assign csr_waddr_o = csr_waddr_q;
  assign imm_o       = imm_q;
  assign op1_sel_o   = op1_q;
  assign op2_sel_o   = op2_q;
  assign alu_sel_o   = alu_q;
  assign br_sel_o    = br_q;
  assign wb_sel_o    = wb_q;
  assign mem_rw_o    = mem_q;
  assign byte_sel_o  = byte_q;
  assign un_sign_o   = un_sign_q;

endmodule

// File: tb/tb_id.sv
// tb_id: directed vectors plus random instruction words checked against a mnemonic-level model of id.
// Follows CSR_EN the same way the design does.
module tb_id;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst, inst_addr;
  logic [4:0]  rs1_raddr_o, rs2_raddr_o, rd_waddr_o;
  logic [11:0] csr_raddr_o, csr_waddr_o;
  logic [31:0] inst_o, inst_addr_o, imm_o;
  logic [1:0]  op1_sel_o, op2_sel_o, mem_rw_o;
  logic [3:0]  alu_sel_o, byte_sel_o;
  logic [2:0]  br_sel_o, wb_sel_o;
  logic        un_sign_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  id dut (
    .clk(clk), .rst(rst), .inst(inst), .inst_addr(inst_addr),
    .rs1_raddr_o(rs1_raddr_o), .rs2_raddr_o(rs2_raddr_o), .csr_raddr_o(csr_raddr_o),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o), .rd_waddr_o(rd_waddr_o),
    .csr_waddr_o(csr_waddr_o), .imm_o(imm_o), .op1_sel_o(op1_sel_o),
    .op2_sel_o(op2_sel_o), .alu_sel_o(alu_sel_o), .br_sel_o(br_sel_o),
    .wb_sel_o(wb_sel_o), .mem_rw_o(mem_rw_o), .byte_sel_o(byte_sel_o),
    .un_sign_o(un_sign_o)
  );

  typedef struct packed {
    logic [4:0]  rs1, rs2, rd;
    logic [11:0] csr_r, csr_w;
    logic [31:0] imm;
    logic [1:0]  op1, op2;
    logic [3:0]  alu;
    logic [2:0]  br, wb;
    logic [1:0]  mem;
    logic [3:0]  bsel;
    logic        un;
  } exp_t;

  // alu code chosen by funct3 before the sub/sra adjustment
  localparam int ALU_F3 [8] = '{1, 3, 4, 5, 6, 7, 9, 10};

  function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
    logic signed [31:0] t;
    t = v << (32 - bits);
    t = t >>> (32 - bits);
    return t;
  endfunction

  function automatic exp_t model(input logic [31:0] w);
    exp_t e;
    int f3, op;
    f3 = int'(w[14:12]);
    op = int'(w[6:0]);
    e = '0;
    e.rs1 = w[19:15];
    e.rs2 = w[24:20];
    e.un = 1'b1;
`ifdef CSR_EN
    e.csr_r = w[31:20];
`endif
    if (op == 'h33 || op == 'h13) begin
      e.rd = w[11:7];
      e.op1 = 1;
      e.wb = 1;
      e.alu = 4'(ALU_F3[f3] + (((f3 == 5) || (op == 'h33 && f3 == 0)) && w[30] ? 1 : 0));
      e.un = (f3 != 3);
      if (op == 'h13) begin
        e.op2 = 3;
        e.imm = sext(w >> 20, 12);
      end else e.op2 = 1;
    end else if (op == 'h03 && f3 != 3 && f3 < 6) begin
      e.rd = w[11:7];
      e.imm = sext(w >> 20, 12);
      e.op1 = 1; e.op2 = 3; e.alu = 1; e.wb = 3; e.mem = 1;
      e.bsel = 4'((1 << (1 << (f3 % 4))) - 1);
      e.un = (f3 < 4);
    end else if (op == 'h23 && f3 < 3) begin
      e.imm = sext(((w >> 25) << 5) | ((w >> 7) & 31), 12);
      e.op1 = 1; e.op2 = 3; e.alu = 1; e.wb = 4; e.mem = 2;
      e.bsel = 4'((1 << (1 << f3)) - 1);
    end else if (op == 'h63 && f3 != 2 && f3 != 3) begin
      e.imm = sext((((w >> 31) & 1) << 12) | (((w >> 7) & 1) << 11) |
                   (((w >> 25) & 63) << 5) | (((w >> 8) & 15) << 1), 13);
      e.op1 = 1; e.op2 = 1; e.alu = 2;
      e.br = 3'(f3 < 2 ? f3 + 2 : f3);
      e.un = (f3 < 6);
    end else if (op == 'h37 || op == 'h17) begin
      e.rd = w[11:7];
      e.imm = w & 32'hFFFF_F000;
      e.op1 = 2; e.alu = 1; e.wb = 1;
      e.op2 = (op == 'h17) ? 2'd2 : 2'd0;
    end else if (op == 'h6F || op == 'h67) begin
      e.rd = w[11:7];
      e.op2 = 2; e.alu = 1; e.br = 1; e.wb = 2;
      if (op == 'h6F) begin
        e.op1 = 2;
        e.imm = sext((((w >> 31) & 1) << 20) | (((w >> 12) & 255) << 12) |
                     (((w >> 20) & 1) << 11) | (((w >> 21) & 1023) << 1), 21);
      end else begin
        e.op1 = 1;
        e.imm = sext(w >> 20, 12);
      end
    end
`ifdef CSR_EN
    else if (op == 'h73 && f3 != 0 && f3 != 4) begin
      e.rd = w[11:7];
      e.csr_w = w[31:20];
      e.op1 = 3; e.wb = 5;
      e.alu = (f3 % 4 == 1) ? 4'd11 : (f3 % 4 == 2) ? 4'd9 : 4'd12;
      if (f3 >= 4) begin
        e.op2 = 3;
        e.imm = (w >> 15) & 31;
      end else begin
        e.op2 = 1;
        e.rs2 = w[19:15];
      end
    end
`endif
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e, input logic [31:0] ei, input logic [31:0] ea);
    chk({tag, ".rs1"}, 32'(rs1_raddr_o), 32'(e.rs1));
    chk({tag, ".rs2"}, 32'(rs2_raddr_o), 32'(e.rs2));
    chk({tag, ".csr_r"}, 32'(csr_raddr_o), 32'(e.csr_r));
    chk({tag, ".inst"}, inst_o, ei);
    chk({tag, ".pc"}, inst_addr_o, ea);
    chk({tag, ".rd"}, 32'(rd_waddr_o), 32'(e.rd));
    chk({tag, ".csr_w"}, 32'(csr_waddr_o), 32'(e.csr_w));
    chk({tag, ".imm"}, imm_o, e.imm);
    chk({tag, ".op1"}, 32'(op1_sel_o), 32'(e.op1));
    chk({tag, ".op2"}, 32'(op2_sel_o), 32'(e.op2));
    chk({tag, ".alu"}, 32'(alu_sel_o), 32'(e.alu));
    chk({tag, ".br"}, 32'(br_sel_o), 32'(e.br));
    chk({tag, ".wb"}, 32'(wb_sel_o), 32'(e.wb));
    chk({tag, ".mem"}, 32'(mem_rw_o), 32'(e.mem));
    chk({tag, ".byte"}, 32'(byte_sel_o), 32'(e.bsel));
    chk({tag, ".un"}, 32'(un_sign_o), 32'(e.un));
  endtask

  task automatic step(input string tag, input logic [31:0] w, input logic [31:0] a);
    inst = w;
    inst_addr = a;
    @(posedge clk);
    #1;
    check_all(tag, model(w), w, a);
  endtask

  localparam int NOPC = 10;
  localparam logic [6:0] OPCS [NOPC] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                                          7'h37, 7'h17, 7'h6F, 7'h67, 7'h73};

  initial begin
    logic [31:0] w;
    rst = 1'b1;
    inst = 32'h0000_0000;
    inst_addr = 32'h0000_0000;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", exp_t'('0), 32'h0, 32'h0);

    @(negedge clk);
    rst = 1'b0;

    step("addi", 32'h00108F93, 32'h0000_1000);
    chk("addi.imm_k", imm_o, 32'h0000_0001);
    chk("addi.rd_k", 32'(rd_waddr_o), 32'd31);
    chk("addi.op2_k", 32'(op2_sel_o), 32'd3);

    step("bge", 32'hFE20D063, 32'h0000_1004);
    chk("bge.br_k", 32'(br_sel_o), 32'd5);
    chk("bge.rs2_k", 32'(rs2_raddr_o), 32'd2);

    step("lh", 32'h00309F83, 32'h0000_1008);
    chk("lh.byte_k", 32'(byte_sel_o), 32'b0011);
    step("sb", 32'h80208223, 32'h0000_100C);
    chk("sb.imm_k", imm_o, 32'hFFFF_F804);
    chk("sb.byte_k", 32'(byte_sel_o), 32'b0001);

    step("lui", 32'h00005FB7, 32'h0000_1010);
    chk("lui.imm_k", imm_o, 32'h0000_5000);
    step("auipc", 32'h00006F97, 32'h0000_1014);
    chk("auipc.op2_k", 32'(op2_sel_o), 32'd2);

    step("sltu", 32'h0020B1B3, 32'h0000_1018);
    step("sub", 32'h402081B3, 32'h0000_101C);
    step("srai", 32'h4030D193, 32'h0000_1020);
    step("lbu", 32'h0000C183, 32'h0000_1024);
    step("bgeu", 32'h0020F463, 32'h0000_1028);
    step("jal", 32'hFFDFF0EF, 32'h0000_102C);
    step("csrrw", 32'h30009173, 32'h0000_1030);
    step("csrrci", 32'h3402F173, 32'h0000_1034);
    step("ld_bad", 32'h0000B183, 32'h0000_1038);
    step("unknown", 32'hFFFF_FF7F, 32'h0000_103C);

    step("jalr", 32'h8070AFE7, 32'h0000_1040);
    chk("jalr.imm_k", imm_o, 32'hFFFF_F807);
    chk("jalr.br_k", 32'(br_sel_o), 32'd1);

    // raise reset between edges: outputs must clear without a clock
    #2 rst = 1'b1;
    #1;
    check_all("rst_async", exp_t'('0), 32'h0, 32'h0);
    inst = 32'h00108F93;
    inst_addr = 32'h0000_2000;
    @(posedge clk);
    #1;
    check_all("rst_hold", exp_t'('0), 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step("post_rst", 32'h00108F93, 32'h0000_2000);

    for (int n = 0; n < 300; n++) begin
      w = $urandom;
      if (n % 8 != 7) w[6:0] = OPCS[$urandom_range(NOPC - 1)];
      step("rand", w, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
